ibex_load_store_unit: RTL

IBEX_LOAD_STORE_UNIT -- requirements
Module: ibex_load_store_unit

---
 rtl/ibex_pkg.sv | 14 +
 rtl/ibex_load_store_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ibex_pkg.sv
// Shared encodings for the load/store unit: access-size codes and the split-access rule.
package ibex_pkg;

  localparam logic [1:0] LSU_TYPE_WORD = 2'b00;
  localparam logic [1:0] LSU_TYPE_HALF = 2'b01;
  localparam logic [1:0] LSU_TYPE_BYTE = 2'b10;

  // An access needs two bus transactions when its bytes straddle a word boundary.
  function automatic logic lsu_is_split(input logic [1:0] lsu_type, input logic [1:0] offset);
    return ((lsu_type == LSU_TYPE_WORD) && (offset != 2'b00)) ||
           ((lsu_type == LSU_TYPE_HALF) && (offset == 2'b11));
  endfunction

endpackage

// File: rtl/ibex_load_store_unit.sv
// RV32 load/store unit: issues one or two word-aligned bus transactions per access,
// aligns store data / byte enables and realigns and extends load data.
module ibex_load_store_unit
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_valid_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic [31:0] addr_last_o,
  output logic        busy_o
);

  localparam logic [2:0] IDLE            = 3'd0;
  localparam logic [2:0] WAIT_GNT_MIS    = 3'd1;
  localparam logic [2:0] WAIT_RVALID_MIS = 3'd2;
  localparam logic [2:0] WAIT_GNT        = 3'd3;
  localparam logic [2:0] WAIT_RVALID     = 3'd4;

  logic [2:0]  ls_fsm_cs, ls_fsm_ns;
  logic        we_q;
  logic [1:0]  type_q;
  logic        sign_ext_q;
  logic [1:0]  offset_q;
  logic [31:0] addr_last_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        idle;
  logic        accept;
  logic        part1_rvalid;
  logic        split_q;
  logic        part2;
  logic        err_final;
  logic [1:0]  cur_type;
  logic [1:0]  cur_off;
  logic [29:0] cur_word;
  logic [31:0] cur_wdata;
  logic [5:0]  wr_shamt;
  logic [5:0]  rd_shamt;
  logic [31:0] rdata_lo;
  logic [31:0] rdata_rot;

  assign idle     = (ls_fsm_cs == IDLE);
  assign accept   = idle & lsu_req_i;
  assign busy_o   = ~idle;

  // In IDLE the request is driven straight from the ID/EX inputs; afterwards from captured state.
  assign cur_type  = idle ? lsu_type_i : type_q;
  assign cur_off   = idle ? adder_result_ex_i[1:0] : offset_q;
  assign cur_word  = idle ? adder_result_ex_i[31:2] : addr_last_q[31:2];
  assign cur_wdata = idle ? lsu_wdata_i : wdata_q;
  assign split_q   = lsu_is_split(type_q, offset_q);
  assign part2     = (ls_fsm_cs == WAIT_GNT) && split_q;

  assign data_addr_o  = {cur_word + 30'(part2), 2'b00};
  assign data_we_o    = idle ? lsu_we_i : we_q;
  assign wr_shamt     = {1'b0, cur_off, 3'b000};
  assign data_wdata_o = (cur_wdata << wr_shamt) | (cur_wdata >> (6'd32 - wr_shamt));

  always_comb begin
    data_be_o = 4'b0000;
    case (cur_type)
      LSU_TYPE_HALF: data_be_o = part2 ? 4'b0001 : (4'b0011 << cur_off);
      LSU_TYPE_BYTE: data_be_o = 4'b0001 << cur_off;
      default:       data_be_o = part2 ? (4'b1111 >> (3'd4 - {1'b0, cur_off}))
                                       : (4'b1111 << cur_off);
    endcase
  end

  // Rotate right across {part2, part1}; a single access rotates its own word.
  assign rd_shamt  = {1'b0, offset_q, 3'b000};
  assign rdata_lo  = split_q ? rdata_q : data_rdata_i;
  assign rdata_rot = (rdata_lo >> rd_shamt) | (data_rdata_i << (6'd32 - rd_shamt));

  always_comb begin
    lsu_rdata_o = rdata_rot;
    case (type_q)
      LSU_TYPE_HALF: lsu_rdata_o = {{16{sign_ext_q & rdata_rot[15]}}, rdata_rot[15:0]};
      LSU_TYPE_BYTE: lsu_rdata_o = {{24{sign_ext_q & rdata_rot[7]}}, rdata_rot[7:0]};
      default:       lsu_rdata_o = rdata_rot;
    endcase
  end

  always_comb begin
    ls_fsm_ns        = ls_fsm_cs;
    data_req_o       = 1'b0;
    lsu_resp_valid_o = 1'b0;
    part1_rvalid     = 1'b0;
    case (ls_fsm_cs)
      IDLE: begin
        if (lsu_req_i) begin
          data_req_o = 1'b1;
          if (lsu_is_split(lsu_type_i, adder_result_ex_i[1:0])) begin
            ls_fsm_ns = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
          end else begin
            ls_fsm_ns = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT_MIS: begin
        data_req_o = 1'b1;
        if (data_gnt_i) ls_fsm_ns = WAIT_RVALID_MIS;
      end
      WAIT_RVALID_MIS: begin
        if (data_rvalid_i) begin
          part1_rvalid = 1'b1;
          ls_fsm_ns    = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) ls_fsm_ns = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          lsu_resp_valid_o = 1'b1;
          ls_fsm_ns        = IDLE;
        end
      end
      default: ls_fsm_ns = IDLE;
    endcase
  end

  assign err_final   = err_q | data_err_i;
  assign load_err_o  = lsu_resp_valid_o & ~we_q & err_final;
  assign store_err_o = lsu_resp_valid_o &  we_q & err_final;
  assign addr_last_o = addr_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ls_fsm_cs   <= IDLE;
      we_q        <= 1'b0;
      type_q      <= LSU_TYPE_WORD;
      sign_ext_q  <= 1'b0;
      offset_q    <= 2'b00;
      addr_last_q <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      ls_fsm_cs <= ls_fsm_ns;
      if (accept) begin
        we_q        <= lsu_we_i;
        type_q      <= lsu_type_i;
        sign_ext_q  <= lsu_sign_ext_i;
        offset_q    <= adder_result_ex_i[1:0];
        addr_last_q <= adder_result_ex_i;
        wdata_q     <= lsu_wdata_i;
        err_q       <= 1'b0;
      end else if (part1_rvalid) begin
        rdata_q <= data_rdata_i;
        if (data_err_i) err_q <= 1'b1;
      end
    end
  end

endmodule
